// File: rtl/mem_write_buffer.sv
// Posted write buffer: cache writes are acknowledged once queued and drained to
// memory in the background. Queued words forward to reads, and read misses bypass the queue.
module mem_write_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] c_a,
  input  logic [31:0] c_st_data,
  input  logic        c_access,
  input  logic        c_write,
  output logic [31:0] c_data,
  output logic        c_ready,
  output logic [31:0] m_a,
  output logic [31:0] m_st_data,
  output logic        m_access,
  output logic        m_write,
  input  logic [31:0] m_data,
  input  logic        m_ready,
  output logic        wb_empty
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR,
    ST_RD
  } state_e;

  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   ONE_CNT = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] ONE_PTR = PTR_W'(1);

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              rd_pending_q, rd_pending_d;
  logic [31:0]       rd_addr_q, rd_addr_d;
  logic              c_ready_q, c_ready_d;
  logic [31:0]       c_data_q, c_data_d;
  logic              m_access_q, m_access_d;
  logic              m_write_q, m_write_d;
  logic [31:0]       m_a_q, m_a_d;
  logic [31:0]       m_st_data_q, m_st_data_d;

  logic [31:0]       addr_mem [DEPTH];
  logic [31:0]       data_mem [DEPTH];

  logic              accept;
  logic              push;
  logic              pop;
  logic              fwd_hit;
  logic [31:0]       fwd_data;

  // Scan oldest to youngest so the last matching entry overrides earlier ones.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (((PTR_W+1)'(k) < count_q) &&
          (addr_mem[head_q + PTR_W'(k)][31:2] == c_a[31:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[head_q + PTR_W'(k)];
      end
    end
  end

  // NOTE: every signal gets a default before any branch, so no latches can be inferred.
  always_comb begin
    state_d      = state_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    rd_pending_d = rd_pending_q;
    rd_addr_d    = rd_addr_q;
    c_ready_d    = 1'b0;
    c_data_d     = c_data_q;
    m_access_d   = m_access_q;
    m_write_d    = m_write_q;
    m_a_d        = m_a_q;
    m_st_data_d  = m_st_data_q;
    push         = 1'b0;
    pop          = 1'b0;

    // A cycle with c_ready high is the ack of the previous request and never re-accepts it.
    accept = c_access && !c_ready_q && !rd_pending_q;

    if (accept) begin
      if (c_write) begin
        if (count_q != DEPTH_C) begin
          push      = 1'b1;
          c_ready_d = 1'b1;
        end
      end else if (fwd_hit) begin
        c_data_d  = fwd_data;
        c_ready_d = 1'b1;
      end else begin
        rd_pending_d = 1'b1;
        rd_addr_d    = c_a;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (rd_pending_q) begin
          state_d    = ST_RD;
          m_access_d = 1'b1;
          m_write_d  = 1'b0;
          m_a_d      = rd_addr_q;
        end else if (count_q != '0) begin
          state_d     = ST_WR;
          m_access_d  = 1'b1;
          m_write_d   = 1'b1;
          m_a_d       = addr_mem[head_q];
          m_st_data_d = data_mem[head_q];
        end
      end
      ST_WR: begin
        if (m_ready) begin
          pop        = 1'b1;
          m_access_d = 1'b0;
          m_write_d  = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      ST_RD: begin
        if (m_ready) begin
          c_data_d     = m_data;
          c_ready_d    = 1'b1;
          rd_pending_d = 1'b0;
          m_access_d   = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (push) tail_d = tail_q + ONE_PTR;
    if (pop)  head_d = head_q + ONE_PTR;
    case ({push, pop})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      rd_pending_q <= 1'b0;
      rd_addr_q    <= '0;
      c_ready_q    <= 1'b0;
      c_data_q     <= '0;
      m_access_q   <= 1'b0;
      m_write_q    <= 1'b0;
      m_a_q        <= '0;
      m_st_data_q  <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      rd_pending_q <= rd_pending_d;
      rd_addr_q    <= rd_addr_d;
      c_ready_q    <= c_ready_d;
      c_data_q     <= c_data_d;
      m_access_q   <= m_access_d;
      m_write_q    <= m_write_d;
      m_a_q        <= m_a_d;
      m_st_data_q  <= m_st_data_d;
    end
  end

  // NOTE: entry storage has no reset; count_q alone decides which slots are valid.
  always_ff @(posedge clock) begin
    if (push) begin
      addr_mem[tail_q] <= c_a;
      data_mem[tail_q] <= c_st_data;
    end
  end

  assign c_ready   = c_ready_q;
  assign c_data    = c_data_q;
  assign m_access  = m_access_q;
  assign m_write   = m_write_q;
  assign m_a       = m_a_q;
  assign m_st_data = m_st_data_q;
  assign wb_empty  = (count_q == '0) && (state_q != ST_WR);

endmodule

// File: tb/tb_mem_write_buffer.sv
// Bench for mem_write_buffer: directed scenarios plus random traffic. A memory
// model logs every bus transaction, and a shadow memory gives the value each read must return.
module tb_mem_write_buffer;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] c_a = '0;
  logic [31:0] c_st_data = '0;
  logic        c_access = 1'b0;
  logic        c_write = 1'b0;
  logic [31:0] c_data;
  logic        c_ready;
  logic [31:0] m_a;
  logic [31:0] m_st_data;
  logic        m_access;
  logic        m_write;
  logic [31:0] m_data = '0;
  logic        m_ready = 1'b0;
  logic        wb_empty;

  mem_write_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clock(clock), .resetn(resetn),
    .c_a(c_a), .c_st_data(c_st_data), .c_access(c_access), .c_write(c_write),
    .c_data(c_data), .c_ready(c_ready),
    .m_a(m_a), .m_st_data(m_st_data), .m_access(m_access), .m_write(m_write),
    .m_data(m_data), .m_ready(m_ready), .wb_empty(wb_empty)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        txn_log[$];
  logic [31:0] mem_model [logic [29:0]];
  logic [31:0] shadow    [logic [29:0]];
  int          n_pass = 0;
  int          n_checks = 0;
  bit          mem_auto = 1'b0;
  int          mem_lat = 2;
  int          ack_req = 0;
  int          wait_cnt = 0;
  int          rd_seen = 0;
  bit          prev_acc = 1'b0;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_model.exists(a[31:2])) return mem_model[a[31:2]];
    return dflt(a);
  endfunction

  // A read must see the most recent acknowledged write, wherever it currently lives.
  function automatic logic [31:0] shadow_rd(input logic [31:0] a);
    if (shadow.exists(a[31:2])) return shadow[a[31:2]];
    return dflt(a);
  endfunction

  // Memory responder: acts 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (m_access && !m_write && !prev_acc) rd_seen++;
      prev_acc = m_access;
      if (!resetn) begin
        m_ready  = 1'b0;
        wait_cnt = 0;
      end else if (m_ready) begin
        m_ready  = 1'b0;
        wait_cnt = 0;
      end else if (m_access) begin
        wait_cnt++;
        if ((mem_auto && wait_cnt >= mem_lat) || (!mem_auto && ack_req > 0)) begin
          if (!mem_auto) ack_req--;
          if (m_write) begin
            mem_model[m_a[31:2]] = m_st_data;
            txn_log.push_back('{1'b1, m_a, m_st_data});
          end else begin
            m_data = mem_rd(m_a);
            txn_log.push_back('{1'b0, m_a, m_data});
          end
          m_ready = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic cache_req(input bit wr, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rdata, output int cycles);
    c_access  = 1'b1;
    c_write   = wr;
    c_a       = a;
    c_st_data = d;
    cycles    = -1;
    rdata     = 'x;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (c_ready) begin
        cycles = i;
        rdata  = c_data;
        break;
      end
    end
    c_access = 1'b0;
    c_write  = 1'b0;
    if (wr && cycles > 0) shadow[a[31:2]] = d;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (wb_empty && !m_access && !m_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #12;
    n_checks++; if (c_ready !== 1'b0) $display("FAIL reset_c_ready: got %b want 0", c_ready); else n_pass++;
    n_checks++; if (c_data !== 32'h0) $display("FAIL reset_c_data: got %h want 0", c_data); else n_pass++;
    n_checks++; if (m_access !== 1'b0 || m_write !== 1'b0)
      $display("FAIL reset_m_ctrl: got access=%b write=%b want 0/0", m_access, m_write); else n_pass++;
    n_checks++; if (m_a !== 32'h0 || m_st_data !== 32'h0)
      $display("FAIL reset_m_bus: got a=%h d=%h want 0/0", m_a, m_st_data); else n_pass++;
    n_checks++; if (wb_empty !== 1'b1) $display("FAIL reset_wb_empty: got %b want 1", wb_empty); else n_pass++;
    @(posedge clock);
    #2;
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    logic [31:0] rd;
    int          cyc;
    bit          ok;
    txn_t        exp;
    mem_auto = 1'b0; ack_req = 0; txn_log.delete();
    cache_req(1'b1, 32'h100, 32'hDEADBEEF, rd, cyc);
    n_checks++; if (cyc != 1) $display("FAIL t1_ack_latency: got %0d want 1", cyc); else n_pass++;
    tick();
    n_checks++; if (m_access !== 1'b1 || m_write !== 1'b1)
      $display("FAIL t1_m_ctrl: got access=%b write=%b want 1/1", m_access, m_write); else n_pass++;
    n_checks++; if (m_a !== 32'h100 || m_st_data !== 32'hDEADBEEF)
      $display("FAIL t1_m_bus: got a=%h d=%h want 100/deadbeef", m_a, m_st_data); else n_pass++;
    ack_req = 1;
    wait_idle(ok);
    n_checks++; if (!ok || wb_empty !== 1'b1 || m_access !== 1'b0)
      $display("FAIL t1_idle_after_ack: got ok=%b wb_empty=%b access=%b want 1/1/0", ok, wb_empty, m_access); else n_pass++;
    exp = '{1'b1, 32'h100, 32'hDEADBEEF};
    n_checks++; if (txn_log.size() != 1 || txn_log[0] !== exp)
      $display("FAIL t1_mem_write: got %0d txns want exactly the write 100/deadbeef", txn_log.size()); else n_pass++;
  endtask

  task automatic test_full();
    logic [31:0] rd;
    logic [31:0] d;
    int          cyc;
    int          ack_tick;
    bit          stalled;
    bit          ok;
    txn_t        exp_q[$];
    mem_auto = 1'b0; ack_req = 0; txn_log.delete();
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      cache_req(1'b1, 32'h2000 + 32'(4 * i), d, rd, cyc);
      n_checks++; if (cyc < 1 || cyc > 2) $display("FAIL t2_ack_%0d: got %0d cycles want 1..2", i, cyc); else n_pass++;
      exp_q.push_back('{1'b1, 32'h2000 + 32'(4 * i), d});
    end
    n_checks++; if (m_access !== 1'b1 || m_write !== 1'b1 || m_a !== 32'h2000)
      $display("FAIL t2_head_in_wr: got access=%b write=%b a=%h want 1/1/2000", m_access, m_write, m_a); else n_pass++;
    d = $urandom;
    c_access = 1'b1; c_write = 1'b1; c_a = 32'h2010; c_st_data = d;
    stalled = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (c_ready) stalled = 1'b1;
    end
    n_checks++; if (stalled) $display("FAIL t2_full_stall: got c_ready=1 want 0 while full"); else n_pass++;
    ack_req  = 1;
    ack_tick = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (c_ready) begin
        ack_tick = i;
        break;
      end
    end
    c_access = 1'b0; c_write = 1'b0;
    shadow[30'(32'h2010 >> 2)] = d;
    exp_q.push_back('{1'b1, 32'h2010, d});
    n_checks++; if (ack_tick != 3) $display("FAIL t2_fifth_ack: got tick %0d want 3", ack_tick); else n_pass++;
    ack_req = 0; mem_auto = 1'b1; mem_lat = 2;
    wait_idle(ok);
    n_checks++; if (!ok || txn_log.size() != 5)
      $display("FAIL t2_drain_count: got ok=%b txns=%0d want 1/5", ok, txn_log.size()); else n_pass++;
    for (int i = 0; i < 5 && i < txn_log.size(); i++) begin
      n_checks++; if (txn_log[i] !== exp_q[i])
        $display("FAIL t2_drain_%0d: got a=%h d=%h want a=%h d=%h", i, txn_log[i].addr, txn_log[i].data,
                 exp_q[i].addr, exp_q[i].data); else n_pass++;
    end
  endtask

  task automatic test_forward();
    logic [31:0] rd;
    int          cyc;
    bit          ok;
    mem_auto = 1'b0; ack_req = 0; rd_seen = 0; txn_log.delete();
    cache_req(1'b1, 32'h104, 32'h11111111, rd, cyc);
    cache_req(1'b1, 32'h104, 32'h22222222, rd, cyc);
    tick();
    cache_req(1'b0, 32'h107, 32'h0, rd, cyc);
    n_checks++; if (cyc != 1) $display("FAIL t3_fwd_latency: got %0d want 1", cyc); else n_pass++;
    n_checks++; if (rd !== 32'h22222222) $display("FAIL t3_fwd_data: got %h want 22222222", rd); else n_pass++;
    tick(); tick(); tick();
    n_checks++; if (rd_seen != 0) $display("FAIL t3_no_mem_read: got %0d reads want 0", rd_seen); else n_pass++;
    mem_auto = 1'b1; mem_lat = 1;
    wait_idle(ok);
    n_checks++; if (!ok || txn_log.size() != 2 || mem_rd(32'h104) !== 32'h22222222)
      $display("FAIL t3_drain: got ok=%b txns=%0d mem=%h want 1/2/22222222", ok, txn_log.size(), mem_rd(32'h104));
    else n_pass++;
  endtask

  task automatic test_read_miss();
    logic [31:0] rd;
    logic [31:0] da;
    logic [31:0] db;
    int          cyc;
    bit          ok;
    txn_t        exp_q[$];
    mem_model[30'(32'h200 >> 2)] = 32'hCAFEF00D;
    shadow[30'(32'h200 >> 2)]    = 32'hCAFEF00D;
    mem_auto = 1'b0; ack_req = 0; txn_log.delete();
    da = $urandom; db = $urandom;
    cache_req(1'b1, 32'h300, da, rd, cyc);
    cache_req(1'b1, 32'h304, db, rd, cyc);
    tick();
    n_checks++; if (m_access !== 1'b1 || m_write !== 1'b1 || m_a !== 32'h300)
      $display("FAIL t4_first_in_wr: got access=%b write=%b a=%h want 1/1/300", m_access, m_write, m_a); else n_pass++;
    mem_auto = 1'b1; mem_lat = 3;
    cache_req(1'b0, 32'h200, 32'h0, rd, cyc);
    n_checks++; if (cyc < 0 || rd !== 32'hCAFEF00D)
      $display("FAIL t4_miss_data: got %h (cycles %0d) want cafef00d", rd, cyc); else n_pass++;
    wait_idle(ok);
    exp_q.push_back('{1'b1, 32'h300, da});
    exp_q.push_back('{1'b0, 32'h200, 32'hCAFEF00D});
    exp_q.push_back('{1'b1, 32'h304, db});
    n_checks++; if (!ok || txn_log.size() != 3)
      $display("FAIL t4_txn_count: got ok=%b txns=%0d want 1/3", ok, txn_log.size()); else n_pass++;
    for (int i = 0; i < 3 && i < txn_log.size(); i++) begin
      n_checks++; if (txn_log[i] !== exp_q[i])
        $display("FAIL t4_order_%0d: got wr=%b a=%h want wr=%b a=%h", i, txn_log[i].wr, txn_log[i].addr,
                 exp_q[i].wr, exp_q[i].addr); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int          cyc;
    bit          seen;
    mem_auto = 1'b0; ack_req = 0;
    for (int i = 0; i < 3; i++) cache_req(1'b1, 32'h400 + 32'(4 * i), $urandom, rd, cyc);
    tick();
    n_checks++; if (m_access !== 1'b1) $display("FAIL t5_busy_before: got access=%b want 1", m_access); else n_pass++;
    resetn = 1'b0;
    #1;
    n_checks++; if (m_access !== 1'b0 || wb_empty !== 1'b1)
      $display("FAIL t5_async_reset: got access=%b wb_empty=%b want 0/1", m_access, wb_empty); else n_pass++;
    tick(); tick();
    resetn = 1'b1;
    txn_log.delete();
    shadow = mem_model;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_access) seen = 1'b1;
    end
    n_checks++; if (seen || txn_log.size() != 0 || wb_empty !== 1'b1)
      $display("FAIL t5_discarded: got access_seen=%b txns=%0d wb_empty=%b want 0/0/1", seen, txn_log.size(), wb_empty);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0] rd;
    logic [31:0] d;
    int          cyc;
    bit          ok;
    txn_t        exp_q[$];
    mem_auto = 1'b1; mem_lat = 2; txn_log.delete();
    for (int i = 0; i < 10; i++) begin
      d = $urandom;
      cache_req(1'b1, 32'h1000 + 32'(4 * i), d, rd, cyc);
      exp_q.push_back('{1'b1, 32'h1000 + 32'(4 * i), d});
      n_checks++; if (cyc < 1) $display("FAIL t6_ack_%0d: got timeout want ack", i); else n_pass++;
    end
    wait_idle(ok);
    n_checks++; if (!ok || txn_log.size() != 10)
      $display("FAIL t6_count: got ok=%b txns=%0d want 1/10", ok, txn_log.size()); else n_pass++;
    for (int i = 0; i < 10 && i < txn_log.size(); i++) begin
      n_checks++; if (txn_log[i] !== exp_q[i])
        $display("FAIL t6_order_%0d: got a=%h d=%h want a=%h d=%h", i, txn_log[i].addr, txn_log[i].data,
                 exp_q[i].addr, exp_q[i].data); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic [31:0] d;
    logic [31:0] a;
    logic [31:0] exp_rd;
    int          cyc;
    int          wi;
    bit          ok;
    bit          wr;
    txn_t        exp_q[$];
    mem_auto = 1'b1; txn_log.delete();
    for (int n = 0; n < 80; n++) begin
      mem_lat = $urandom_range(1, 4);
      wr      = 1'($urandom_range(0, 1));
      a       = 32'h3000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      if (wr) begin
        d = $urandom;
        cache_req(1'b1, a, d, rd, cyc);
        exp_q.push_back('{1'b1, a, d});
        n_checks++; if (cyc < 1) $display("FAIL rnd_wr_ack_%0d: got timeout want ack", n); else n_pass++;
      end else begin
        exp_rd = shadow_rd(a);
        cache_req(1'b0, a, 32'h0, rd, cyc);
        n_checks++; if (cyc < 1 || rd !== exp_rd)
          $display("FAIL rnd_rd_%0d: addr %h got %h want %h", n, a, rd, exp_rd); else n_pass++;
      end
      if ($urandom_range(0, 3) == 0) tick();
    end
    wait_idle(ok);
    wi = 0;
    for (int i = 0; i < txn_log.size(); i++) begin
      if (txn_log[i].wr) begin
        if (wi < exp_q.size() && txn_log[i] !== exp_q[wi]) begin
          wi = -1000;
        end
        wi++;
      end
    end
    n_checks++; if (!ok || wi != exp_q.size())
      $display("FAIL rnd_write_order: got ok=%b matched=%0d want %0d writes in order", ok, wi, exp_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_full();
    test_forward();
    test_read_miss();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_write_buffer.md
Name: mem_write_buffer

Overview:
Posted write buffer between the cache/TLB memory port and physical main memory. Cache writes are acknowledged as soon as they are queued, then drained to memory in the background. Reads that hit a queued word are forwarded from the buffer. Reads that miss are sent to memory ahead of any remaining queued writes. One blocking request is outstanding on the cache side at any time.

Parameters:
DEPTH, 4, number of buffered write entries (power of two)
PTR_W, 2, log2(DEPTH)

Ports:
clock  input  1  system clock
resetn  input  1  asynchronous active-low reset
c_a  input  32  cache-side byte address
c_st_data  input  32  cache-side store data
c_access  input  1  cache request; held with c_a/c_st_data/c_write stable until c_ready
c_write  input  1  1 = write, 0 = read
c_data  output  32  read data to cache; valid while c_ready=1
c_ready  output  1  one-cycle acknowledge to cache
m_a  output  32  memory address
m_st_data  output  32  memory store data
m_access  output  1  memory request; held until m_ready
m_write  output  1  memory write enable
m_data  input  32  memory read data; valid while m_ready=1
m_ready  input  1  one-cycle memory completion pulse
wb_empty  output  1  buffer holds no entries and no memory write is in flight

Behaviour:
- Reset (async, resetn=0): FIFO emptied and head/tail/count cleared. rd_pending=0. Outputs: c_ready=0, c_data=0, m_access=0, m_write=0, m_a=0, m_st_data=0, wb_empty=1.
- Reset mid-operation: queued writes are discarded, and m_access drops immediately.
- Cache acceptance:
  - A request is evaluated at an edge with c_access=1, c_ready=0 and rd_pending=0.
  - No request is evaluated at an edge where c_ready=1; this prevents double acceptance.
- Write accepted:
  - If count<DEPTH: enqueue {c_a, c_st_data} at tail; c_ready=1 for exactly the next cycle.
  - If full: no action; c_ready stays 0 and the request is retried each edge.
- Read, forwarding:
  - Compare c_a[31:2] against all valid entries. The youngest match wins.
  - On a hit: c_data<=entry data, c_ready=1 next cycle, and no memory access is made.
- Read miss: set rd_pending. c_ready stays 0 until memory returns.
- Memory port FSM: states IDLE, WR, RD.
  - IDLE:
    - If rd_pending: go to RD with m_access=1, m_write=0, m_a=latched read address.
    - Else if FIFO non-empty: go to WR with m_access=1, m_write=1, {m_a, m_st_data}=head entry.
    - Reads have priority over draining.
  - WR: on an edge with m_ready=1, pop head, m_access<=0, m_write<=0, return to IDLE.
  - RD: on an edge with m_ready=1:
    - c_data<=m_data, c_ready=1 next cycle.
    - rd_pending<=0, m_access<=0, return to IDLE.
  - m_access is always low for at least one cycle between transactions.
  - m_a and m_st_data hold their last values when idle.
- Simultaneous enqueue and pop on one edge: count unchanged; both pointers advance modulo DEPTH.
- A pop in the same edge frees a slot for the next edge only. Full is evaluated on the pre-edge count.
- A read miss does not wait for the FIFO to drain. It waits only for an in-flight WR to complete.
- wb_empty = (count==0) and not in state WR.
- Pointer wrap: head and tail wrap from DEPTH-1 to 0.

Test Plan:
1. Idle, write 0x100/0xDEADBEEF:
   - c_ready high the next cycle.
   - The following cycle: m_access=1, m_write=1, m_a=0x100.
   - m_ready pulse -> m_access=0, wb_empty=1.
2. Hold m_ready=0 and issue 5 writes:
   - The first 4 are acked; one is in WR and 3 are queued, so count=4.
   - The 5th write sees c_ready=0 until the first m_ready, then is acked the cycle after.
3. Write 0x104/0x11111111 then 0x104/0x22222222 with memory stalled, then read 0x107:
   - c_data=0x22222222 and c_ready the next cycle.
   - m_write=0 is never asserted, i.e. no memory read.
4. Two writes queued with the first in WR, then read miss 0x200:
   - After the first m_ready, the next transaction is RD at 0x200.
   - m_data=0xCAFEF00D returns c_data=0xCAFEF00D.
   - The second write drains afterwards.
5. Three entries queued, m_access=1, assert resetn=0:
   - m_access=0 and wb_empty=1 immediately.
   - After release, no memory transaction occurs.
6. Wrap test: 10 sequential writes with m_ready returned 2 cycles after each m_access:
   - Memory sees all 10 addresses in issue order with the correct data.
